// File: rtl/systolic_edge_feeder_pkg.sv
// Shared definitions for the systolic edge feeder: the bit-exact FP32 zero,
// the 2-bit FSM encodings and a counter-width helper.
package systolic_edge_feeder_pkg;

    // PE zero-detect keys on an all-zero word, so -0.0 (32'h8000_0000) is
    // never used as padding.
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // Feeder FSM encodings.
    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/systolic_edge_feeder_lane_skew.sv
// One edge lane of the feeder. Captures the whole operand beat whose index
// equals the lane number (A row i for left lane i, B column j for top lane j)
// and, on each stream step t, emits element t-LANE of it or zero when t-LANE
// falls outside the buffer. The lane output is registered.
module systolic_edge_feeder_lane_skew
    import systolic_edge_feeder_pkg::*;
#(
    parameter int N    = 4,
    parameter int DW   = 32,
    parameter int LANE = 0,
    parameter int SW   = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [N*DW-1:0]   i_wr_vec,
    input  logic              i_load_step,
    input  logic [SW-1:0]     i_step,
    output logic [DW-1:0]     o_lane
);

    logic [N-1:0][DW-1:0] r_buf;
    logic [DW-1:0]        r_lane;
    logic [DW-1:0]        w_sel;

    // Capture this lane's operand vector when its beat is accepted.
    // NOTE: the operand buffer has no reset; it is always rewritten by a full
    // fill before anything reads it, and skipping reset keeps it plain flops.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_buf <= i_wr_vec;
        end
    end

    // Skew select: element (step - LANE) if it exists, otherwise zero.
    // NOTE: w_sel is given a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_sel = DW'(FP_ZERO);
        for (int e = 0; e < N; e++) begin
            if (i_step == SW'(LANE + e)) begin
                w_sel = r_buf[e];
            end
        end
    end

    // Lane output register: the selected element while streaming, zero otherwise.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lane <= DW'(FP_ZERO);
        end else if (i_load_step) begin
            r_lane <= w_sel;
        end else begin
            r_lane <= DW'(FP_ZERO);
        end
    end

    assign o_lane = r_lane;

endmodule

// File: rtl/systolic_edge_feeder.sv
// Transmit side of the PE edge interface. Accepts N load beats (A row k and
// B column k per beat), then streams the operands skewed and zero-padded onto
// the left and top edges of an NxN PE grid for 2N-1 steps, holds zeros for
// DRAIN_CYC cycles and pulses DONE. The top holds the FSM and counters; the
// per-lane buffers and skew selection live in the lane sub-modules.
module systolic_edge_feeder
    import systolic_edge_feeder_pkg::*;
#(
    parameter int N         = 4,
    parameter int DW        = 32,
    parameter int DRAIN_CYC = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LD_VALID,
    output logic              LD_READY,
    input  logic [N*DW-1:0]   LD_A_ROW,
    input  logic [N*DW-1:0]   LD_B_COL,
    output logic [N*DW-1:0]   OUT_LEFT,
    output logic [N*DW-1:0]   OUT_TOP,
    output logic              BUSY,
    output logic              DONE
);

    localparam int BW  = cnt_width(N - 1);
    localparam int SW  = cnt_width(2 * N - 2);
    localparam int DCW = cnt_width(DRAIN_CYC - 1);

    localparam logic [BW-1:0]  BEAT_LAST  = BW'(N - 1);
    localparam logic [SW-1:0]  STEP_LAST  = SW'(2 * N - 2);
    localparam logic [DCW-1:0] DRAIN_LAST = (DRAIN_CYC > 0) ? DCW'(DRAIN_CYC - 1) : '0;

    logic [1:0]     r_state;
    logic [BW-1:0]  r_beat;
    logic [SW-1:0]  r_step;
    logic [DCW-1:0] r_drain;
    logic           r_ld_ready;
    logic           r_busy;
    logic           r_done;

    logic           w_accept;
    logic           w_load_step;
    logic [N-1:0]   w_wr_en;

    assign w_accept    = LD_VALID && r_ld_ready;
    assign w_load_step = (r_state == ST_STREAM);

    // Route each accepted beat to the lane whose index matches the beat count.
    always_comb begin
        w_wr_en = '0;
        for (int k = 0; k < N; k++) begin
            w_wr_en[k] = w_accept && (r_beat == BW'(k));
        end
    end

    // Feeder FSM with beat, step and drain counters; BUSY/DONE/LD_READY are
    // registered alongside the state so they line up with it exactly.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_FILL;
            r_beat     <= '0;
            r_step     <= '0;
            r_drain    <= '0;
            r_ld_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        if (r_beat == BEAT_LAST) begin
                            r_state    <= ST_STREAM;
                            r_beat     <= '0;
                            r_step     <= '0;
                            r_ld_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    // The lanes load step r_step on this edge.
                    if (r_step == STEP_LAST) begin
                        if (DRAIN_CYC == 0) begin
                            // No drain window: the last step is still on the
                            // lanes during the DONE cycle in this configuration.
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                            r_drain <= '0;
                        end
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                default: begin
                    // ST_DONE: single-cycle DONE, then back to a fresh fill.
                    r_state    <= ST_FILL;
                    r_done     <= 1'b0;
                    r_beat     <= '0;
                    r_step     <= '0;
                    r_drain    <= '0;
                    r_ld_ready <= 1'b1;
                end
            endcase
        end
    end

    // One left lane (A rows) and one top lane (B columns) per array edge position.
    for (genvar g = 0; g < N; g++) begin : g_lane
        systolic_edge_feeder_lane_skew #(
            .N    (N),
            .DW   (DW),
            .LANE (g),
            .SW   (SW)
        ) u_left (
            .i_clk       (CLK),
            .i_rst       (RST),
            .i_wr_en     (w_wr_en[g]),
            .i_wr_vec    (LD_A_ROW),
            .i_load_step (w_load_step),
            .i_step      (r_step),
            .o_lane      (OUT_LEFT[g*DW +: DW])
        );

        systolic_edge_feeder_lane_skew #(
            .N    (N),
            .DW   (DW),
            .LANE (g),
            .SW   (SW)
        ) u_top (
            .i_clk       (CLK),
            .i_rst       (RST),
            .i_wr_en     (w_wr_en[g]),
            .i_wr_vec    (LD_B_COL),
            .i_load_step (w_load_step),
            .i_step      (r_step),
            .o_lane      (OUT_TOP[g*DW +: DW])
        );
    end

    assign LD_READY = r_ld_ready;
    assign BUSY     = r_busy;
    assign DONE     = r_done;

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Directed bench for systolic_edge_feeder (N=4, DRAIN_CYC=16).
module tb_systolic_edge_feeder;

    localparam int N         = 4;
    localparam int DW        = 32;
    localparam int DRAIN_CYC = 16;
    localparam int VW        = N * DW;
    localparam int NSTEP     = 2 * N - 1;

    localparam logic [31:0] ONE = 32'h3F80_0000;
    localparam logic [31:0] TWO = 32'h4000_0000;

    logic          CLK = 1'b0;
    logic          RST;
    logic          LD_VALID;
    logic          LD_READY;
    logic [VW-1:0] LD_A_ROW;
    logic [VW-1:0] LD_B_COL;
    logic [VW-1:0] OUT_LEFT;
    logic [VW-1:0] OUT_TOP;
    logic          BUSY;
    logic          DONE;

    always #5 CLK = ~CLK;

    systolic_edge_feeder #(
        .N         (N),
        .DW        (DW),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .LD_VALID (LD_VALID),
        .LD_READY (LD_READY),
        .LD_A_ROW (LD_A_ROW),
        .LD_B_COL (LD_B_COL),
        .OUT_LEFT (OUT_LEFT),
        .OUT_TOP  (OUT_TOP),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    // Expected edge vectors for one stream step, lanes packed {3,2,1,0}.
    typedef struct {
        logic [VW-1:0] left;
        logic [VW-1:0] top;
    } step_vec_t;

    step_vec_t   vec [NSTEP];
    logic [31:0] amat [N][N];
    logic [31:0] bmat [N][N];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Beat k carries A row k (element i at lane i) and B column k (element j at lane j).
    function automatic logic [VW-1:0] beat_a(input int k);
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = amat[k][i];
        return v;
    endfunction

    function automatic logic [VW-1:0] beat_b(input int k);
        logic [VW-1:0] v;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = bmat[j][k];
        return v;
    endfunction

    // Reference skew: left lane i = A[i][t-i], top lane j = B[t-j][j], else zero.
    function automatic logic [VW-1:0] model_left(input int t);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[i*DW +: DW] = amat[i][t-i];
        return v;
    endfunction

    function automatic logic [VW-1:0] model_top(input int t);
        logic [VW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[j*DW +: DW] = bmat[t-j][j];
        return v;
    endfunction

    // Present N beats; with toggle, LD_VALID drops for one cycle between beats
    // while junk sits on the data buses.
    task automatic load_pass(input bit toggle);
        for (int k = 0; k < N; k++) begin
            @(negedge CLK);
            check($sformatf("ld_ready_fill_b%0d", k), VW'(LD_READY), VW'(1'b1));
            LD_VALID = 1'b1;
            LD_A_ROW = beat_a(k);
            LD_B_COL = beat_b(k);
            if (toggle && k < N - 1) begin
                @(negedge CLK);
                check($sformatf("busy_fill_gap%0d", k), VW'(BUSY), VW'(1'b0));
                LD_VALID = 1'b0;
                LD_A_ROW = '1;
                LD_B_COL = '1;
            end
        end
    endtask

    // Follow a pass from the cycle after the accepting edge E (c0) through the
    // return to FILL (c24). abort_t >= 0 asserts RST once step abort_t is visible.
    task automatic stream_pass(input bit use_table, input bit hold_valid, input int abort_t);
        logic [VW-1:0] exp_l;
        logic [VW-1:0] exp_t;
        @(negedge CLK);
        check("busy_c0", VW'(BUSY), VW'(1'b1));
        check("ld_ready_c0", VW'(LD_READY), VW'(1'b0));
        check("left_c0", OUT_LEFT, '0);
        check("top_c0", OUT_TOP, '0);
        LD_VALID = hold_valid;
        LD_A_ROW = '1;
        LD_B_COL = '1;
        for (int t = 0; t < NSTEP; t++) begin
            @(negedge CLK);
            exp_l = use_table ? vec[t].left : model_left(t);
            exp_t = use_table ? vec[t].top  : model_top(t);
            check($sformatf("left_t%0d", t), OUT_LEFT, exp_l);
            check($sformatf("top_t%0d", t), OUT_TOP, exp_t);
            check($sformatf("busy_t%0d", t), VW'(BUSY), VW'(1'b1));
            check($sformatf("done_t%0d", t), VW'(DONE), VW'(1'b0));
            if (t == abort_t) begin
                #1 RST = 1'b1;
                #1;
                check("left_rst", OUT_LEFT, '0);
                check("top_rst", OUT_TOP, '0);
                check("ld_ready_rst", VW'(LD_READY), VW'(1'b1));
                check("busy_rst", VW'(BUSY), VW'(1'b0));
                check("done_rst", VW'(DONE), VW'(1'b0));
                LD_VALID = 1'b0;
                @(negedge CLK);
                RST = 1'b0;
                return;
            end
        end
        for (int c = NSTEP + 1; c <= NSTEP + DRAIN_CYC; c++) begin
            @(negedge CLK);
            check($sformatf("left_c%0d", c), OUT_LEFT, '0);
            check($sformatf("top_c%0d", c), OUT_TOP, '0);
            check($sformatf("busy_c%0d", c), VW'(BUSY), VW'(c < NSTEP + DRAIN_CYC));
            check($sformatf("done_c%0d", c), VW'(DONE), VW'(c == NSTEP + DRAIN_CYC));
            check($sformatf("ld_ready_c%0d", c), VW'(LD_READY), VW'(1'b0));
        end
        LD_VALID = 1'b0;
        @(negedge CLK);
        check("ld_ready_refill", VW'(LD_READY), VW'(1'b1));
        check("busy_refill", VW'(BUSY), VW'(1'b0));
        check("done_refill", VW'(DONE), VW'(1'b0));
        check("left_refill", OUT_LEFT, '0);
    endtask

    initial begin
        // Hand-computed steps for A = identity, B = all 2.0.
        vec[0] = '{left: {32'h0, 32'h0, 32'h0, ONE}, top: {32'h0, 32'h0, 32'h0, TWO}};
        vec[1] = '{left: {32'h0, 32'h0, 32'h0, 32'h0}, top: {32'h0, 32'h0, TWO, TWO}};
        vec[2] = '{left: {32'h0, 32'h0, ONE, 32'h0}, top: {32'h0, TWO, TWO, TWO}};
        vec[3] = '{left: {32'h0, 32'h0, 32'h0, 32'h0}, top: {TWO, TWO, TWO, TWO}};
        vec[4] = '{left: {32'h0, ONE, 32'h0, 32'h0}, top: {TWO, TWO, TWO, 32'h0}};
        vec[5] = '{left: {32'h0, 32'h0, 32'h0, 32'h0}, top: {TWO, TWO, 32'h0, 32'h0}};
        vec[6] = '{left: {ONE, 32'h0, 32'h0, 32'h0}, top: {TWO, 32'h0, 32'h0, 32'h0}};

        RST      = 1'b1;
        LD_VALID = 1'b0;
        LD_A_ROW = '0;
        LD_B_COL = '0;
        repeat (2) @(negedge CLK);
        check("left_reset", OUT_LEFT, '0);
        check("top_reset", OUT_TOP, '0);
        check("ld_ready_reset", VW'(LD_READY), VW'(1'b1));
        check("busy_reset", VW'(BUSY), VW'(1'b0));
        check("done_reset", VW'(DONE), VW'(1'b0));
        RST = 1'b0;

        // Pass 1: identity / 2.0, LD_VALID toggling during fill, held high afterwards.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                amat[r][c] = (r == c) ? ONE : 32'h0;
                bmat[r][c] = TWO;
            end
        load_pass(1'b1);
        stream_pass(1'b1, 1'b1, -1);

        // Pass 2: asymmetric data, back-to-back beats, reset once step 3 is visible.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                amat[r][c] = 32'hA000_0000 | 32'(r * 16 + c + 1);
                bmat[r][c] = 32'hB000_0000 | 32'(r * 16 + c + 1);
            end
        load_pass(1'b0);
        stream_pass(1'b0, 1'b0, 3);

        // Pass 3: fresh asymmetric load after the abort streams cleanly.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                amat[r][c] = 32'h3C00_0000 | 32'((r << 8) | (c << 4) | 4'h5);
                bmat[r][c] = 32'h4100_0000 | 32'((c << 8) | (r << 4) | 4'h9);
            end
        load_pass(1'b0);
        stream_pass(1'b0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
